// File: rtl/instruction_fetcher_pkg.sv
// Shared definitions for the instruction fetcher: RV32I control-flow opcodes,
// fetcher FSM encodings and the default address width.
package instruction_fetcher_pkg;

  localparam int ADDR_W_DEF = 17;

  // RV32I major opcodes the fetcher has to recognise before queueing
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Fetch sequencing states
  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,  // pulse a request at pc
    ST_WAIT      = 2'd1,  // request outstanding, waiting for the word
    ST_PUSH      = 2'd2,  // word buffered, pushing into the queue
    ST_WAIT_JALR = 2'd3   // JALR queued, fetch parked until a redirect
  } fetch_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of one RV32I word: classifies control flow,
// extracts the J/B immediates and forms the predicted and alternate PCs.
module fetch_predecode
  import instruction_fetcher_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pred_take_i,
  output logic              is_jalr_o,
  output logic              take_o,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] alt_pc_o
);

  logic [6:0]        opc;
  logic              is_jal;
  logic              is_branch;
  logic [ADDR_W-1:0] imm_j;
  logic [ADDR_W-1:0] imm_b;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jal_tgt;
  logic [ADDR_W-1:0] br_tgt;

  assign opc       = opcode_of(inst_i);
  assign is_jal    = (opc == OP_JAL);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jalr_o = (opc == OP_JALR);

  // Sign-extended immediates, truncated to the fetch address width; all
  // address arithmetic wraps silently modulo 2^ADDR_W.
  assign imm_j = ADDR_W'({{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                          inst_i[20], inst_i[30:21], 1'b0});
  assign imm_b = ADDR_W'({{19{inst_i[31]}}, inst_i[31], inst_i[7],
                          inst_i[30:25], inst_i[11:8], 1'b0});

  assign seq_pc  = pc_i + ADDR_W'(4);
  assign jal_tgt = pc_i + imm_j;
  assign br_tgt  = pc_i + imm_b;

  // Pick the followed path and the one downstream recovers to on a mispredict
  always_comb begin
    take_o    = 1'b0;
    next_pc_o = seq_pc;
    alt_pc_o  = seq_pc;
    if (is_jal) begin
      take_o    = 1'b1;
      next_pc_o = jal_tgt;
      alt_pc_o  = seq_pc;
    end else if (is_branch) begin
      take_o    = pred_take_i;
      next_pc_o = pred_take_i ? br_tgt : seq_pc;
      alt_pc_o  = pred_take_i ? seq_pc : br_tgt;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch front end: owns the fetch PC, keeps one I-cache request in flight,
// pre-decodes each returned word and pushes it into the instruction queue
// with its prediction, redirecting on flush.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              icache_req_valid,
  output logic [ADDR_W-1:0] icache_req_addr,
  input  logic              icache_resp_valid,
  input  logic [31:0]       icache_resp_inst,
  output logic [ADDR_W-1:0] pred_q_address,
  input  logic              pred_q_take,
  input  logic              iq_full,
  output logic              iq_push,
  output logic [31:0]       iq_inst,
  output logic [ADDR_W-1:0] iq_pc,
  output logic              iq_pred_take,
  output logic [ADDR_W-1:0] iq_alt_pc,
  input  logic              flush_en,
  input  logic [ADDR_W-1:0] flush_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       buf_inst_q, buf_inst_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic              discard_q, discard_d;

  logic              pd_is_jalr;
  logic              pd_take;
  logic [ADDR_W-1:0] pd_next_pc;
  logic [ADDR_W-1:0] pd_alt_pc;

  fetch_predecode #(
    .ADDR_W(ADDR_W)
  ) u_predecode (
    .inst_i     (buf_inst_q),
    .pc_i       (buf_pc_q),
    .pred_take_i(pred_q_take),
    .is_jalr_o  (pd_is_jalr),
    .take_o     (pd_take),
    .next_pc_o  (pd_next_pc),
    .alt_pc_o   (pd_alt_pc)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_PC;
      buf_inst_q <= '0;
      buf_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      discard_q  <= discard_d;
    end
  end

  // Next-state: flush overrides everything; a flush while a request is in
  // flight arms discard so the stale word is dropped when it lands.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    discard_d  = discard_q;
    if (flush_en) begin
      pc_d = flush_pc;
      case (state_q)
        ST_WAIT: begin
          if (icache_resp_valid) begin
            discard_d = 1'b0;
            state_d   = ST_ISSUE;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = ST_ISSUE;
      endcase
    end else begin
      case (state_q)
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (icache_resp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = ST_ISSUE;
            end else begin
              buf_inst_d = icache_resp_inst;
              buf_pc_d   = pc_q;
              state_d    = ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          if (!iq_full) begin
            if (pd_is_jalr) begin
              state_d = ST_WAIT_JALR;
            end else begin
              pc_d    = pd_next_pc;
              state_d = ST_ISSUE;
            end
          end
        end
        default: state_d = ST_WAIT_JALR;
      endcase
    end
  end

  // Outputs: all quiet in reset; buffered word is presented throughout PUSH
  always_comb begin
    icache_req_valid = 1'b0;
    icache_req_addr  = '0;
    pred_q_address   = '0;
    iq_push          = 1'b0;
    iq_inst          = '0;
    iq_pc            = '0;
    iq_pred_take     = 1'b0;
    iq_alt_pc        = '0;
    if (!rst) begin
      case (state_q)
        ST_ISSUE: begin
          icache_req_valid = !flush_en;
          icache_req_addr  = pc_q;
        end
        ST_PUSH: begin
          pred_q_address = buf_pc_q;
          iq_inst        = buf_inst_q;
          iq_pc          = buf_pc_q;
          iq_pred_take   = pd_take;
          iq_alt_pc      = pd_alt_pc;
          iq_push        = !iq_full && !flush_en;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: a behavioural I-cache with
// programmable latency, a program table walked in a loop, and hand-written
// sequences for JALR stall, flushes, queue back-pressure, wrap and reset.
module tb_instruction_fetcher;

  localparam int AW = 17;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JALR = 32'h0000_8067;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_req_valid;
  logic [AW-1:0] icache_req_addr;
  logic          icache_resp_valid;
  logic [31:0]   icache_resp_inst;
  logic [AW-1:0] pred_q_address;
  logic          pred_q_take;
  logic          iq_full;
  logic          iq_push;
  logic [31:0]   iq_inst;
  logic [AW-1:0] iq_pc;
  logic          iq_pred_take;
  logic [AW-1:0] iq_alt_pc;
  logic          flush_en;
  logic [AW-1:0] flush_pc;

  always #5 clk = ~clk;

  instruction_fetcher #(.ADDR_W(AW), .RESET_PC(17'h0)) dut (
    .clk(clk), .rst(rst),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_resp_valid(icache_resp_valid), .icache_resp_inst(icache_resp_inst),
    .pred_q_address(pred_q_address), .pred_q_take(pred_q_take),
    .iq_full(iq_full), .iq_push(iq_push), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_pred_take(iq_pred_take), .iq_alt_pc(iq_alt_pc),
    .flush_en(flush_en), .flush_pc(flush_pc)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   inst;
    logic          take;
    logic [AW-1:0] alt;
    logic [AW-1:0] qa;
  } push_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   inst;
    logic          pred;
    logic          take;
    logic [AW-1:0] alt;
    logic [AW-1:0] nxt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0]   mem [logic [AW-1:0]];
  logic [AW-1:0] req_q [$];
  push_t         push_q [$];
  logic          pend_active;
  int            pend_cnt;
  logic [AW-1:0] pend_addr;
  int            lat;

  vec_t vt [8];

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] i;
    i = off[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_beq(input int off);
    logic [12:0] i;
    i = off[12:0];
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : ADDI;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Sample the current cycle, advance one clock, then drive the cache response
  task automatic tick();
    #1;
    if (!rst) begin
      if (icache_req_valid) begin
        chk("one_outstanding", {31'd0, pend_active}, 32'd0);
        req_q.push_back(icache_req_addr);
        pend_active = 1'b1;
        pend_cnt    = lat;
        pend_addr   = icache_req_addr;
      end
      if (iq_push)
        push_q.push_back('{iq_pc, iq_inst, iq_pred_take, iq_alt_pc, pred_q_address});
    end
    @(posedge clk);
    #1;
    icache_resp_valid = 1'b0;
    if (rst) begin
      pend_active = 1'b0;
    end else if (pend_active) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        icache_resp_valid = 1'b1;
        icache_resp_inst  = rd_mem(pend_addr);
        pend_active       = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input logic [AW-1:0] exp, input string nm);
    for (int i = 0; i < 40 && req_q.size() == 0; i++) tick();
    if (req_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: no request seen, want %0h", nm, exp);
    end else begin
      chk(nm, req_q.pop_front(), exp);
    end
  endtask

  task automatic wait_push(input logic [AW-1:0] pc, input logic [31:0] inst,
                           input logic take, input logic [AW-1:0] alt, input string nm);
    push_t p;
    for (int i = 0; i < 40 && push_q.size() == 0; i++) tick();
    if (push_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: no push seen, want pc %0h", nm, pc);
    end else begin
      p = push_q.pop_front();
      chk({nm, "_pc"},   p.pc,   pc);
      chk({nm, "_inst"}, p.inst, inst);
      chk({nm, "_take"}, {31'd0, p.take}, {31'd0, take});
      chk({nm, "_alt"},  p.alt,  alt);
      chk({nm, "_qa"},   p.qa,   pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; icache_resp_valid = 1'b0; icache_resp_inst = '0;
    pred_q_take = 1'b0; iq_full = 1'b0; flush_en = 1'b0; flush_pc = '0;
    pend_active = 1'b0; pend_cnt = 0; pend_addr = '0; lat = 2;

    //       addr      inst               pred  take  alt       next
    vt[0] = '{17'h0,   ADDI,              1'b0, 1'b0, 17'h4,   17'h4};
    vt[1] = '{17'h4,   ADDI,              1'b1, 1'b0, 17'h8,   17'h8};
    vt[2] = '{17'h8,   enc_jal(32'h100),  1'b0, 1'b1, 17'hC,   17'h108};
    vt[3] = '{17'h108, enc_jal(-232),     1'b0, 1'b1, 17'h10C, 17'h20};
    vt[4] = '{17'h20,  enc_beq(-8),       1'b1, 1'b1, 17'h24,  17'h18};
    vt[5] = '{17'h18,  enc_jal(8),        1'b0, 1'b1, 17'h1C,  17'h20};
    vt[6] = '{17'h20,  enc_beq(-8),       1'b0, 1'b0, 17'h18,  17'h24};
    vt[7] = '{17'h24,  enc_jal(32'h1C),   1'b0, 1'b1, 17'h28,  17'h40};
    foreach (vt[i]) mem[vt[i].addr] = vt[i].inst;
    mem[17'h40]    = JALR;
    mem[17'h1FFF0] = enc_jal(32'h20);

    // Reset: outputs quiet
    tick(); tick();
    chk("rst_req_valid", {31'd0, icache_req_valid}, 32'd0);
    chk("rst_req_addr",  icache_req_addr, 32'd0);
    chk("rst_iq_push",   {31'd0, iq_push}, 32'd0);
    chk("rst_pred_addr", pred_q_address, 32'd0);
    chk("rst_iq_pc",     iq_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("first_req_cycle", req_q.size(), 32'd1);
    wait_req(17'h0, "req0");

    // Program walk: each entry pushes, then the next fetch address follows
    for (int i = 0; i < 8; i++) begin
      pred_q_take = vt[i].pred;
      wait_push(vt[i].addr, vt[i].inst, vt[i].take, vt[i].alt, $sformatf("vec%0d", i));
      wait_req(vt[i].nxt, $sformatf("vec%0d_next", i));
    end
    pred_q_take = 1'b0;

    // JALR parks fetch until commit redirects
    wait_push(17'h40, JALR, 1'b0, 17'h44, "jalr");
    repeat (5) tick();
    chk("jalr_stall", req_q.size(), 32'd0);
    flush_en = 1'b1; flush_pc = 17'h80;
    tick();
    flush_en = 1'b0;
    wait_req(17'h80, "jalr_redirect");
    wait_push(17'h80, ADDI, 1'b0, 17'h84, "after_jalr");

    // Flush one cycle after a request: the stale word is dropped
    wait_req(17'h84, "req84");
    flush_en = 1'b1; flush_pc = 17'h50;
    tick();
    flush_en = 1'b0;
    lat = 4;
    wait_req(17'h50, "flush_50");
    chk("drop_84", push_q.size(), 32'd0);
    // Two back-to-back flushes while waiting; only the latest target survives
    flush_en = 1'b1; flush_pc = 17'h300;
    tick();
    flush_pc = 17'h200;
    tick();
    flush_en = 1'b0;
    lat = 2;
    wait_req(17'h200, "flush_200");
    chk("drop_50", push_q.size(), 32'd0);
    wait_push(17'h200, ADDI, 1'b0, 17'h204, "push_200");

    // Queue full for three PUSH cycles
    wait_req(17'h204, "req204");
    iq_full = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("full_nopush%0d", k), {31'd0, iq_push}, 32'd0);
      chk($sformatf("full_qa%0d", k), pred_q_address, 17'h204);
      tick();
    end
    chk("full_held", push_q.size(), 32'd0);
    iq_full = 1'b0;
    wait_push(17'h204, ADDI, 1'b0, 17'h208, "push_204");

    // Flush while full: buffered word dropped
    wait_req(17'h208, "req208");
    iq_full = 1'b1;
    tick(); tick();
    flush_en = 1'b1; flush_pc = 17'h300;
    tick();
    flush_en = 1'b0; iq_full = 1'b0;
    wait_req(17'h300, "flush_full");
    chk("drop_208", push_q.size(), 32'd0);
    wait_push(17'h300, ADDI, 1'b0, 17'h304, "push_300");

    // Flush in ISSUE suppresses that cycle's request
    flush_en = 1'b1; flush_pc = 17'h1FFF0;
    tick();
    flush_en = 1'b0;
    chk("issue_suppress", req_q.size(), 32'd0);
    wait_req(17'h1FFF0, "flush_top");
    // JAL past the top of the address space wraps
    wait_push(17'h1FFF0, enc_jal(32'h20), 1'b1, 17'h1FFF4, "wrap");
    wait_req(17'h10, "wrap_next");

    // Reset while a request is outstanding
    rst = 1'b1;
    tick(); tick();
    chk("midrst_req", {31'd0, icache_req_valid}, 32'd0);
    chk("midrst_push", {31'd0, iq_push}, 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_first", req_q.size(), 32'd1);
    wait_req(17'h0, "midrst_req0");
    wait_push(17'h0, ADDI, 1'b0, 17'h4, "midrst_push0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Front-end stage directly upstream of the instruction queue and its branch predictor.
- Holds the architectural fetch PC and issues one outstanding instruction-cache request at a time.
- Pre-decodes each returned RV32I word to pick the next PC. JAL is always taken; conditional branches take the predictor's answer; JALR stalls fetch.
- Pushes each instruction into the queue with its PC, predicted-taken flag and alternate (non-predicted) PC, which downstream uses for recovery; redirects on flush.

Parameters:
- ADDR_W, 17, width of all instruction addresses.
- RESET_PC, 17'h0, fetch PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- icache_req_valid  out  1  one-cycle request pulse
- icache_req_addr  out  ADDR_W  request address, valid with pulse
- icache_resp_valid  in  1  one-cycle response pulse, exactly one per request
- icache_resp_inst  in  32  instruction word, valid with resp pulse
- pred_q_address  out  ADDR_W  predictor query address
- pred_q_take  in  1  predictor answer, combinational, same cycle
- iq_full  in  1  queue cannot accept this cycle
- iq_push  out  1  push strobe
- iq_inst  out  32  pushed instruction
- iq_pc  out  ADDR_W  pushed instruction's PC
- iq_pred_take  out  1  predicted taken (1 for JAL, 0 for non-control)
- iq_alt_pc  out  ADDR_W  PC to resume at if the prediction is wrong
- flush_en  in  1  redirect from commit (mispredict or JALR resolve)
- flush_pc  in  ADDR_W  redirect target

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- State machine:
  - States: ISSUE, WAIT, PUSH, WAIT_JALR.
  - Registers: pc, buf_inst, buf_pc, discard flag.
- Reset:
  - state=ISSUE, pc=RESET_PC, discard=0.
  - All outputs 0 during the reset cycle.
  - First request pulse occurs in the first cycle after rst deasserts.
- ISSUE:
  - Drive icache_req_valid=1 with icache_req_addr=pc for one cycle, then go to WAIT.
- WAIT:
  - On icache_resp_valid, latch buf_inst=icache_resp_inst and buf_pc=pc, then go to PUSH.
  - If discard=1, drop the response, clear discard and go to ISSUE.
- PUSH:
  - iq_inst, iq_pc and pred_q_address are driven from buf_* combinationally.
  - If !iq_full, assert iq_push and update state as follows:
    - JAL (opcode 1101111): take=1, pc=buf_pc+immJ, alt=buf_pc+4, go ISSUE.
    - Branch (1100011): take=pred_q_take, target=buf_pc+immB. pc=take?target:buf_pc+4; alt is the other one. Go ISSUE.
    - JALR (1100111): take=0, alt=buf_pc+4, go WAIT_JALR. Fetch halts until flush.
    - Other opcodes: take=0, pc=alt=buf_pc+4, go ISSUE.
  - If iq_full, hold in PUSH with outputs stable and iq_push=0.
- Timing: best-case response-to-push latency is 1 cycle; push-to-next-request is 1 cycle.
- Arithmetic:
  - Immediates are sign-extended to ADDR_W.
  - Sums are truncated modulo 2^ADDR_W, so wrap-around is silent.
  - iq_* outputs other than iq_push are don't-care when iq_push=0; the bench compares them only on pushes.
- Flush (priority over everything else in that cycle):
  - pc=flush_pc in every state.
  - ISSUE: the request pulse this cycle is suppressed; go ISSUE.
  - WAIT without a response this cycle: set discard=1 and stay in WAIT.
  - WAIT with a response this cycle: drop the response; go ISSUE.
  - PUSH: no push this cycle, buffer dropped; go ISSUE.
  - WAIT_JALR: go ISSUE.
- Repeated flushes in WAIT keep discard=1, and only the latest flush_pc is kept.
- Invariant: never more than one request outstanding.
- rst asserted mid-request returns the block to its reset state. The cache is reset by the same rst, so no discard tracking is needed across reset.

Decomposition:
- Shared include file: RV32I opcode constants (OP_JAL, OP_JALR, OP_BRANCH), fetcher state encodings, ADDR_W default.
- One natural combinational sub-module, fetch_predecode:
  - Inputs: inst, pc, pred_take.
  - Outputs: is_jalr, take, next_pc, alt_pc.
  - Contains immJ/immB extraction and the adders.

Test Plan:
- Reset, cache latency 2, words at 0x0/0x4 are ADDI → requests at 0x0 then 0x4; pushes have iq_pc 0x0/0x4, take=0, alt 0x4/0x8.
- JAL +0x100 at 0x8 → push take=1, alt=0xC; next request addr 0x108.
- BEQ -8 at 0x20 with pred_q_take=1 → pred_q_address=0x20 during push; next request 0x18, alt=0x24. Repeat with take=0 → next request 0x24, alt=0x18.
- JALR at 0x40 → push take=0, alt=0x44, no further requests; flush_pc=0x80 after 5 cycles → next request 0x80.
- Flush to 0x200 one cycle after a request to 0x50 → that response is dropped with no push; next request is 0x200, and its response is pushed with iq_pc=0x200.
- iq_full held 3 cycles in PUSH → iq_push=0 and outputs stable; push on the cycle full drops. Flush while full → no push, next request at flush_pc.
